// File: rtl/ptp_a_driver_if.sv
// Word handshake and byte-bus signals of the paper-tape-port word driver.
// master = the driver itself; slave = the host/receiver side that talks to it.
interface ptp_a_driver_if;
  logic [31:0] word_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  value_o;
  logic        control_o;
  logic        ptp_rst_n_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    input  word_i, valid_i,
    output ready_o, value_o, control_o, ptp_rst_n_o, busy_o, done_o
  );

  modport slave (
    output word_i, valid_i,
    input  ready_o, value_o, control_o, ptp_rst_n_o, busy_o, done_o
  );
endinterface

// File: rtl/ptp_a_driver.sv
// Sends one 32-bit word as four MSB-first bytes, each framed by setup/strobe/hold.
// Optional macro PTP_DRIVER_RESET_PULSE_EN prefixes every word with a receiver reset pulse.
module ptp_a_driver #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int RST_CYCLES    = 2
) (
    input  logic           clock,
    input  logic           reset_i,
    ptp_a_driver_if.master bus,
    output logic [2:0]     dbg_state
);

    localparam int M1   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int M2   = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
    localparam int MAXC = (M2 > RST_CYCLES) ? M2 : RST_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3
`ifdef PTP_DRIVER_RESET_PULSE_EN
        , S_RST  = 3'd4
`endif
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic [31:0]   word_q;
    logic [31:0]   src;
    logic [7:0]    value_q, value_nx;
    logic          control_q, control_nx;
    logic          done_q, done_nx;
    logic          accept;

    // Handshake: a word transfers on a rising edge where valid_i and ready_o are
    // both high; ready_o is high exactly in IDLE, and valid_i is ignored otherwise.
    assign accept = (state == S_IDLE) && bus.valid_i;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        idx_nx   = idx;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (accept) begin
                    idx_nx = 2'd0;
`ifdef PTP_DRIVER_RESET_PULSE_EN
                    state_nx = S_RST;
`else
                    state_nx = S_SETUP;
`endif
                end
            end
`ifdef PTP_DRIVER_RESET_PULSE_EN
            S_RST: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_SETUP;
                end
            end
`endif
            S_SETUP: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cnt == CW'(STROBE_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    cnt_nx = '0;
                    if (idx == 2'd3) begin
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx   = idx + 2'd1;
                        state_nx = S_SETUP;
                    end
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // The first byte comes straight from word_i because the latch fills on the same edge.
    always_comb begin
        src      = (state == S_IDLE) ? bus.word_i : word_q;
        value_nx = value_q;
        if ((state_nx == S_SETUP) && (state != S_SETUP)) begin
            case (idx_nx)
                2'd0:    value_nx = src[31:24];
                2'd1:    value_nx = src[23:16];
                2'd2:    value_nx = src[15:8];
                default: value_nx = src[7:0];
            endcase
        end
        control_nx = (state_nx == S_STROBE);
        done_nx    = (state == S_HOLD) && (state_nx == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 2'd0;
            word_q    <= 32'h0;
            value_q   <= 8'h00;
            control_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            if (accept) word_q <= bus.word_i;
            value_q   <= value_nx;
            control_q <= control_nx;
            done_q    <= done_nx;
        end
    end

`ifdef PTP_DRIVER_RESET_PULSE_EN
    logic ptp_rst_n_q;

    always_ff @(posedge clock) begin
        if (reset_i) ptp_rst_n_q <= 1'b1;
        else         ptp_rst_n_q <= (state_nx != S_RST);
    end

    assign bus.ptp_rst_n_o = ptp_rst_n_q;
`else
    assign bus.ptp_rst_n_o = 1'b1;
`endif

    assign bus.ready_o   = (state == S_IDLE);
    assign bus.busy_o    = (state != S_IDLE);
    assign bus.value_o   = value_q;
    assign bus.control_o = control_q;
    assign bus.done_o    = done_q;
    assign dbg_state     = state;

endmodule
